// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_sel channel selector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    MAN   = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_dwell_counter.sv
// DWELL-modulo cycle counter for scan pacing.
// tick is high while the count sits at DWELL-1; clr forces 0, hold freezes.
module mux_dwell_counter #(
  parameter int unsigned DWELL = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..DWELL-1 and wrap; clear has priority over hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel, W-bit registered data selector with manual and round-robin scan
// modes and a VALID/RDY output handshake.
// Optional build macro MUX_STROBE_EN adds the active-low strobe input G_N;
// while G_N is high every sample loads zero data.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CH*WIDTH-1:0] DIN,
  input  logic                MODE,
  input  logic [SEL_W-1:0]    SEL,
  input  logic                LOAD,
  input  logic                RDY,
`ifdef MUX_STROBE_EN
  input  logic                G_N,
`endif
  output logic                VALID,
  output logic [WIDTH-1:0]    DOUT,
  output logic [SEL_W-1:0]    CH_OUT,
  output logic                WRAP,
  output logic                ERR
);

  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W + 1)'(CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_nxt;
  logic [SEL_W-1:0]   src_ptr;
  logic               slot_free;
  logic               sel_ok;
  logic               take;
  logic               cnt_clr;
  logic               cnt_hold;
  logic               cnt_tick;
  logic               wrap_nxt;
  logic               err_nxt;
  logic [WIDTH-1:0]   slice;
  logic [WIDTH-1:0]   sample;

  logic               valid_q;
  logic [WIDTH-1:0]   dout_q;
  logic [SEL_W-1:0]   ch_q;
  logic               wrap_q;
  logic               err_q;

  assign slot_free = !valid_q || RDY;
  assign sel_ok    = ({1'b0, SEL} < CH_EXT);

  mux_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .hold  (cnt_hold),
    .tick  (cnt_tick)
  );

  // Next-state, pointer and sample-enable decode.
  // A mode change owns its cycle: no sample is taken and LOAD is ignored.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    src_ptr   = ptr;
    take      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_hold  = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      MAN: begin
        cnt_clr = 1'b1;
        if (MODE == MODE_SCAN) begin
          state_nxt = SCAN;
        end else begin
          if (LOAD) begin
            if (sel_ok) begin
              ptr_nxt = SEL;
              src_ptr = SEL;
            end else begin
              err_nxt = 1'b1;
            end
          end
          take = slot_free;
        end
      end
      SCAN, STALL: begin
        if (MODE == MODE_MAN) begin
          state_nxt = MAN;
          cnt_clr   = 1'b1;
        end else if (cnt_tick) begin
          if (slot_free) begin
            take      = 1'b1;
            state_nxt = SCAN;
            wrap_nxt  = (ptr == LAST_CH);
            ptr_nxt   = (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
          end else begin
            state_nxt = STALL;
            cnt_hold  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = MAN;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Channel slice selected by the effective pointer.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (src_ptr == SEL_W'(k)) begin
        slice = DIN[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUX_STROBE_EN
  assign sample = G_N ? '0 : slice;
`else
  assign sample = slice;
`endif

  // FSM, pointer, status pulses and the handshaked output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= MAN;
      ptr     <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      wrap_q <= wrap_nxt;
      err_q  <= err_nxt;
      if (take) begin
        dout_q  <= sample;
        ch_q    <= src_ptr;
        valid_q <= 1'b1;
      end else if (valid_q && RDY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign VALID  = valid_q;
  assign DOUT   = dout_q;
  assign CH_OUT = ch_q;
  assign WRAP   = wrap_q;
  assign ERR    = err_q;

endmodule
